// File: rtl/y86_scoreboard_if.sv
// Decode/writeback bundle between the y86 pipeline and the register scoreboard.
interface y86_scoreboard_if #(
  parameter int NREG = 8
);
  logic [3:0]      srcA;
  logic [3:0]      srcB;
  logic            issue_valid;
  logic [3:0]      issue_dstE;
  logic [3:0]      issue_dstM;
  logic            writeE;
  logic [3:0]      Wout_dstE;
  logic            writeM;
  logic [3:0]      Wout_dstM;
  logic            cancel_valid;
  logic [3:0]      cancel_dstE;
  logic [3:0]      cancel_dstM;
  logic            busyA;
  logic            busyB;
  logic            d_stall;
  logic [NREG-1:0] pending;
  logic            err_ovf;
  logic            err_unf;

  modport master (
    output srcA, srcB, issue_valid, issue_dstE, issue_dstM,
           writeE, Wout_dstE, writeM, Wout_dstM,
           cancel_valid, cancel_dstE, cancel_dstM,
    input  busyA, busyB, d_stall, pending, err_ovf, err_unf
  );

  modport slave (
    input  srcA, srcB, issue_valid, issue_dstE, issue_dstM,
           writeE, Wout_dstE, writeM, Wout_dstM,
           cancel_valid, cancel_dstE, cancel_dstM,
    output busyA, busyB, d_stall, pending, err_ovf, err_unf
  );
endinterface

// File: rtl/y86_scoreboard.sv
// Per-register in-flight write counters for the y86 pipeline. Issue increments,
// writeback or cancellation decrements; decode reads busy flags to stall.
module y86_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 8
) (
  input  logic          clk,
  input  logic          reset,
  y86_scoreboard_if.slave sb
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SUM_W = CNT_W + 3;
  localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_p1  [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  ovf_hit;
  logic [NREG-1:0]  unf_hit;
  logic [NREG-1:0]  pend;
  logic             err_ovf_p1;
  logic             err_unf_p1;

  // One unit of count when an enabled port names register r; ids >= NREG never match.
  function automatic logic signed [SUM_W-1:0] hit(input logic en, input logic [3:0] id,
                                                   input int r);
    hit = '0;
    if (en && (int'(id) == r)) hit = SUM_W'(1);
  endfunction

  // Clip a signed net count into [0, max]; returns {ovf, unf, count}.
  function automatic logic [CNT_W+1:0] sat_cnt(input logic signed [SUM_W-1:0] sum);
    if (sum > CNT_MAX)
      sat_cnt = {1'b1, 1'b0, CNT_MAX[CNT_W-1:0]};
    else if (sum < 0)
      sat_cnt = {1'b0, 1'b1, {CNT_W{1'b0}}};
    else
      sat_cnt = {1'b0, 1'b0, sum[CNT_W-1:0]};
  endfunction

  // Net increment/decrement per register with saturation at both ends.
  always_comb begin
    logic signed [SUM_W-1:0] inc;
    logic signed [SUM_W-1:0] dec;
    logic signed [SUM_W-1:0] sum;
    inc     = '0;
    dec     = '0;
    sum     = '0;
    ovf_hit = '0;
    unf_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      inc = hit(sb.issue_valid, sb.issue_dstE, r) + hit(sb.issue_valid, sb.issue_dstM, r);
      dec = hit(sb.writeE, sb.Wout_dstE, r) + hit(sb.writeM, sb.Wout_dstM, r)
          + hit(sb.cancel_valid, sb.cancel_dstE, r) + hit(sb.cancel_valid, sb.cancel_dstM, r);
      sum = $signed({3'b000, cnt_p1[r]}) + inc - dec;
      {ovf_hit[r], unf_hit[r], cnt_nxt[r]} = sat_cnt(sum);
    end
  end

  // Counter and sticky error state; reset empties the scoreboard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt_p1[r] <= '0;
      err_ovf_p1 <= 1'b0;
      err_unf_p1 <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_p1[r] <= cnt_nxt[r];
      err_ovf_p1 <= err_ovf_p1 | (|ovf_hit);
      err_unf_p1 <= err_unf_p1 | (|unf_hit);
    end
  end

  // Busy view from registered counters only: no same-cycle bypass of retires.
  always_comb begin
    pend = '0;
    for (int r = 0; r < NREG; r++) pend[r] = (cnt_p1[r] != '0);
  end

  assign sb.pending = pend;
  assign sb.busyA   = (int'(sb.srcA) < NREG) && pend[sb.srcA[IDX_W-1:0]];
  assign sb.busyB   = (int'(sb.srcB) < NREG) && pend[sb.srcB[IDX_W-1:0]];
  assign sb.d_stall = sb.busyA | sb.busyB;
  assign sb.err_ovf = err_ovf_p1;
  assign sb.err_unf = err_unf_p1;

endmodule

// File: tb/tb_y86_scoreboard.sv
// Bench for y86_scoreboard: directed table plus randomized traffic against a counting model.
module tb_y86_scoreboard;

  typedef struct packed {
    logic       iv;
    logic [3:0] ie;
    logic [3:0] im;
    logic       we;
    logic [3:0] wde;
    logic       wm;
    logic [3:0] wdm;
    logic       cv;
    logic [3:0] ce;
    logic [3:0] cm;
    logic [3:0] sa;
    logic [3:0] sbr;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic       ba;
    logic       bb;
    logic [7:0] pend;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Reference state: how many writes each register still owes, plus sticky flags.
  int   mc [8];
  bit   mo;
  bit   mu;

  y86_scoreboard_if #(.NREG(8)) sb_if ();

  y86_scoreboard #(.CNT_W(2), .NREG(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  function automatic stim_t mk_s(input logic iv, input logic [3:0] ie, input logic [3:0] im,
                                 input logic we, input logic [3:0] wde,
                                 input logic wm, input logic [3:0] wdm,
                                 input logic cv, input logic [3:0] ce, input logic [3:0] cm,
                                 input logic [3:0] sa, input logic [3:0] sbr);
    stim_t s;
    s.iv = iv; s.ie = ie; s.im = im;
    s.we = we; s.wde = wde; s.wm = wm; s.wdm = wdm;
    s.cv = cv; s.ce = ce; s.cm = cm;
    s.sa = sa; s.sbr = sbr;
    return s;
  endfunction

  function automatic vec_t mk_v(input stim_t s, input logic ba, input logic bb,
                                input logic [7:0] pend, input logic ovf, input logic unf);
    vec_t v;
    v.s = s; v.ba = ba; v.bb = bb; v.pend = pend; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  function automatic stim_t rand_s();
    stim_t s;
    s.iv  = ($urandom_range(0, 1) == 0);
    s.ie  = 4'($urandom_range(0, 15));
    s.im  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
    s.we  = ($urandom_range(0, 2) == 0);
    s.wde = 4'($urandom_range(0, 15));
    s.wm  = ($urandom_range(0, 3) == 0);
    s.wdm = 4'($urandom_range(0, 15));
    s.cv  = ($urandom_range(0, 4) == 0);
    s.ce  = 4'($urandom_range(0, 15));
    s.cm  = 4'($urandom_range(0, 15));
    s.sa  = 4'($urandom_range(0, 15));
    s.sbr = 4'($urandom_range(0, 15));
    return s;
  endfunction

  task automatic drive(input stim_t s);
    sb_if.issue_valid  = s.iv;
    sb_if.issue_dstE   = s.ie;
    sb_if.issue_dstM   = s.im;
    sb_if.writeE       = s.we;
    sb_if.Wout_dstE    = s.wde;
    sb_if.writeM       = s.wm;
    sb_if.Wout_dstM    = s.wdm;
    sb_if.cancel_valid = s.cv;
    sb_if.cancel_dstE  = s.ce;
    sb_if.cancel_dstM  = s.cm;
    sb_if.srcA         = s.sa;
    sb_if.srcB         = s.sbr;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) mc[r] = 0;
    mo = 0;
    mu = 0;
  endtask

  // Count every matching id: issues add, writebacks and cancels subtract, then clip.
  task automatic model_update(input stim_t s);
    int n;
    for (int r = 0; r < 8; r++) begin
      n = mc[r];
      if (s.iv && int'(s.ie) == r) n++;
      if (s.iv && int'(s.im) == r) n++;
      if (s.we && int'(s.wde) == r) n--;
      if (s.wm && int'(s.wdm) == r) n--;
      if (s.cv && int'(s.ce) == r) n--;
      if (s.cv && int'(s.cm) == r) n--;
      if (n > 3) begin n = 3; mo = 1; end
      if (n < 0) begin n = 0; mu = 1; end
      mc[r] = n;
    end
  endtask

  function automatic logic model_busy(input logic [3:0] id);
    if (int'(id) < 8) return (mc[int'(id)] != 0);
    return 1'b0;
  endfunction

  task automatic check_model(input stim_t s);
    logic [7:0] ep;
    logic       ea;
    logic       eb;
    for (int r = 0; r < 8; r++) ep[r] = (mc[r] != 0);
    ea = model_busy(s.sa);
    eb = model_busy(s.sbr);
    chk8("model_pending", sb_if.pending, ep);
    chk1("model_busyA", sb_if.busyA, ea);
    chk1("model_busyB", sb_if.busyB, eb);
    chk1("model_d_stall", sb_if.d_stall, ea | eb);
    chk1("model_err_ovf", sb_if.err_ovf, logic'(mo));
    chk1("model_err_unf", sb_if.err_unf, logic'(mu));
  endtask

  // One cycle: drive right after the edge, check before the next edge, then clock it in.
  task automatic run_cycle(input stim_t s);
    drive(s);
    #2;
    check_model(s);
    @(posedge clk);
    model_update(s);
    #1;
  endtask

  task automatic check_empty(input string tag);
    chk8({tag, "_pending"}, sb_if.pending, 8'h00);
    chk1({tag, "_d_stall"}, sb_if.d_stall, 1'b0);
    chk1({tag, "_err_ovf"}, sb_if.err_ovf, 1'b0);
    chk1({tag, "_err_unf"}, sb_if.err_unf, 1'b0);
  endtask

  vec_t tbl[$];

  initial begin
    stim_t s;
    vec_t  v;
    checks = 0;
    errors = 0;
    model_clear();

    // Directed vectors: inputs for the cycle, outputs expected during that cycle.
    tbl.push_back(mk_v(mk_s(1,4'h0,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h0,4'hF), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 1,4'h0, 0,4'hF, 0,4'hF,4'hF, 4'h0,4'hF), 1,0,8'h01,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h0,4'hF), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(1,4'h4,4'h4, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h4,4'hF), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 1,4'h4, 0,4'hF, 0,4'hF,4'hF, 4'h4,4'hF), 1,0,8'h10,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 1,4'h4, 0,4'hF,4'hF, 4'h4,4'hF), 1,0,8'h10,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h4,4'hF), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(1,4'h2,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'hF,4'h2), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(1,4'h2,4'hF, 1,4'h2, 0,4'hF, 0,4'hF,4'hF, 4'hF,4'h2), 0,1,8'h04,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'hF,4'h2), 0,1,8'h04,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 1,4'h2, 0,4'hF, 0,4'hF,4'hF, 4'hF,4'h2), 0,1,8'h04,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'hF,4'h2), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(1,4'h3,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h3,4'hF), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 1,4'h3,4'hF, 4'h3,4'hF), 1,0,8'h08,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 1,4'h3,4'hF, 4'h3,4'hF), 0,0,8'h00,0,0));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h3,4'hF), 0,0,8'h00,0,1));
    tbl.push_back(mk_v(mk_s(1,4'h1,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h1,4'hF), 0,0,8'h00,0,1));
    tbl.push_back(mk_v(mk_s(1,4'h1,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h1,4'hF), 1,0,8'h02,0,1));
    tbl.push_back(mk_v(mk_s(1,4'h1,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h1,4'hF), 1,0,8'h02,0,1));
    tbl.push_back(mk_v(mk_s(1,4'h1,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h1,4'hF), 1,0,8'h02,0,1));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h8,4'h1), 0,1,8'h02,1,1));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'hF,4'h9), 0,0,8'h02,1,1));
    tbl.push_back(mk_v(mk_s(1,4'h8,4'hF, 1,4'hF, 1,4'hC, 1,4'hA,4'hB, 4'h1,4'hF), 1,0,8'h02,1,1));
    tbl.push_back(mk_v(mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h1,4'hF), 1,0,8'h02,1,1));

    // Reset held low with inputs toggling: scoreboard stays empty.
    reset = 1'b0;
    drive(rand_s());
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      drive(rand_s());
      #1;
      check_empty("reset_hold");
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    s = mk_s(0,4'hF,4'hF, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h0,4'h0);
    drive(s);
    #1;
    chk1("post_reset_busyA", sb_if.busyA, 1'b0);
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.s);
      #2;
      chk1($sformatf("vec%0d_busyA", i), sb_if.busyA, v.ba);
      chk1($sformatf("vec%0d_busyB", i), sb_if.busyB, v.bb);
      chk1($sformatf("vec%0d_d_stall", i), sb_if.d_stall, v.ba | v.bb);
      chk8($sformatf("vec%0d_pending", i), sb_if.pending, v.pend);
      chk1($sformatf("vec%0d_err_ovf", i), sb_if.err_ovf, v.ovf);
      chk1($sformatf("vec%0d_err_unf", i), sb_if.err_unf, v.unf);
      check_model(v.s);
      @(posedge clk);
      model_update(v.s);
      #1;
    end

    // Mid-operation asynchronous reset empties the scoreboard immediately.
    drive(mk_s(1,4'h5,4'h6, 0,4'hF, 0,4'hF, 0,4'hF,4'hF, 4'h1,4'h5));
    #2;
    reset = 1'b0;
    #1;
    check_empty("async_reset");
    chk1("async_reset_busyA", sb_if.busyA, 1'b0);
    @(posedge clk);
    #1;
    check_empty("async_reset_edge");
    reset = 1'b1;
    model_clear();

    // Randomized traffic, with another reset partway through.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1'b0;
        #1;
        check_empty("rand_reset");
        reset = 1'b1;
        model_clear();
      end
      run_cycle(rand_s());
    end

    // Gentler random traffic that respects the no-issue-on-stall rule.
    model_clear();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = rand_s();
      s.cv = 1'b0;
      s.we = s.we && model_busy(s.wde);
      s.wm = s.wm && model_busy(s.wdm) && (s.wdm != s.wde);
      if (model_busy(s.sa) || model_busy(s.sbr)) s.iv = 1'b0;
      run_cycle(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
